// File: rtl/InstructionStruct.sv
// Shared widths, FSM state encoding and request-queue entry layout
// for the CPU-side memory bus requester.
package InstructionStruct;

  localparam int DWIDTH    = 32;
  localparam int CPUAWIDTH = 32;
  localparam int AWIDTH    = CPUAWIDTH - 2;

  localparam logic MEM_RD = 1'b1;
  localparam logic MEM_WR = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_RD,
    WAIT_WR,
    TURN
  } mreq_state_e;

  typedef struct packed {
    logic                 rw;
    logic [CPUAWIDTH-1:0] addr;
    logic [DWIDTH-1:0]    wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_requester_req_fifo.sv
// req_fifo: synchronous FIFO of mem_req_t, DEPTH a power of 2.
// Ports: clk, rst_n (async low), push_i/pop_i, din_i/dout_o, full_o/empty_o.
module req_fifo
  import InstructionStruct::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push_i,
  input  logic     pop_i,
  input  mem_req_t din_i,
  output mem_req_t dout_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int PW = $clog2(DEPTH);

  mem_req_t      mem_q [DEPTH];
  logic [PW-1:0] wr_q;
  logic [PW-1:0] rd_q;
  logic [PW:0]   cnt_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = cnt_q == (PW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (do_pop) begin
        rd_q <= rd_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/mem_requester.sv
// mem_requester: queues core load/store requests and runs them one at a
// time on the shared tri-state memory bus; returns load data / write done.
// Ports: clk, reset (async low); core side req_*, rsp_*, wr_done;
// bus side mem_valid, mem_rw, mem_addr, mem_data (inout).
// Build option MEM_ALIGN_CHECK_EN adds align_err and drops misaligned requests.
module mem_requester
  import InstructionStruct::*;
#(
  parameter int RD_LAT  = 2,
  parameter int WR_HOLD = 2,
  parameter int QDEPTH  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_rw,
  input  logic [CPUAWIDTH-1:0] req_addr,
  input  logic [DWIDTH-1:0]    req_wdata,
  output logic                 rsp_valid,
  output logic [DWIDTH-1:0]    rsp_rdata,
  output logic                 wr_done,
`ifdef MEM_ALIGN_CHECK_EN
  output logic                 align_err,
`endif
  inout  wire  [DWIDTH-1:0]    mem_data,
  output logic [CPUAWIDTH-1:0] mem_addr,
  output logic                 mem_rw,
  output logic                 mem_valid
);

  localparam int CW = 8;
  localparam logic [CW-1:0] RD_END = CW'(RD_LAT);
  localparam logic [CW-1:0] WR_END = CW'(WR_HOLD - 1);

  mreq_state_e       state_q, state_d;
  mem_req_t          cur_q, cur_d;
  mem_req_t          head;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              wr_done_q, wr_done_d;
  logic [DWIDTH-1:0] rdata_q, rdata_d;
  logic              full, empty;
  logic              accept, push, pop;
  logic              drive;

  assign req_ready = !full;
  assign accept    = req_valid && req_ready;

`ifdef MEM_ALIGN_CHECK_EN
  logic align_err_q;
  // Misaligned requests are consumed but never queued.
  assign push      = accept && (req_addr[1:0] == 2'b00);
  assign align_err = align_err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      align_err_q <= 1'b0;
    end else begin
      align_err_q <= accept && (req_addr[1:0] != 2'b00);
    end
  end
`else
  assign push = accept;
`endif

  req_fifo #(
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   ({req_rw, req_addr, req_wdata}),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  // Bus drivers follow the registered state, so an async reset
  // releases the bus at once.
  assign mem_valid = state_q == ISSUE;
  assign mem_rw    = cur_q.rw;
  assign mem_addr  = cur_q.addr;
  assign drive     = (state_q == ISSUE && cur_q.rw == MEM_WR)
                  || state_q == WAIT_WR;
  assign mem_data  = drive ? cur_q.wdata : {DWIDTH{1'bz}};

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign wr_done   = wr_done_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cur_q       <= '{rw: MEM_RD, addr: '0, wdata: '0};
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      wr_done_q   <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      wr_done_q   <= wr_done_d;
      rdata_q     <= rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    cnt_d       = cnt_q;
    pop         = 1'b0;
    rsp_valid_d = 1'b0;
    wr_done_d   = 1'b0;
    rdata_d     = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          cur_d   = head;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = CW'(1);
        state_d = (cur_q.rw == MEM_RD) ? WAIT_RD : WAIT_WR;
      end
      WAIT_RD: begin
        if (cnt_q == RD_END) begin
          rdata_d     = mem_data;
          rsp_valid_d = 1'b1;
          cnt_d       = '0;
          state_d     = TURN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_WR: begin
        // ISSUE already counted as the first driven cycle.
        if (cnt_q == WR_END) begin
          wr_done_d = 1'b1;
          cnt_d     = '0;
          state_d   = TURN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      TURN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: doc/mem_requester.md
Name: mem_requester

Overview:
- CPU-side initiator for the shared word-addressed memory bus; the memory controller is the responder on the other end.
- Accepts load/store requests from the CPU core through a valid/ready handshake and buffers them in a 2-entry queue.
- Issues each request on the bus (valid, rw, addr, tri-state data), drives write data, and captures read data at a fixed latency.
- Returns read data to the core with a one-cycle response strobe.

Parameters:
- RD_LAT, 2: rising edges from the edge mem_valid is first high to the edge read data is captured from mem_data (≥2).
- WR_HOLD, 2: cycles mem_data is driven for a write, counted from the issue cycle (≥2).
- QDEPTH, 2: request queue entries (power of 2, ≥2).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  core request present.
- req_ready  out  1  queue can accept a request.
- req_rw  in  1  1 = read, 0 = write (bus encoding).
- req_addr  in  CPUAWIDTH  byte address.
- req_wdata  in  DWIDTH  store data.
- rsp_valid  out  1  one-cycle strobe; rsp_rdata is valid.
- rsp_rdata  out  DWIDTH  load data.
- wr_done  out  1  one-cycle strobe; a write finished its hold window.
- mem_data  inout  DWIDTH  shared bidirectional data bus.
- mem_addr  out  CPUAWIDTH  bus address.
- mem_rw  out  1  bus direction, 1 = read.
- mem_valid  out  1  bus request strobe.

Behaviour:
- Reset (reset=0, async): queue empty; FSM in IDLE; all counters 0; mem_valid=0, mem_rw=1, mem_addr=0; mem_data tri-stated ('z); req_ready=1, rsp_valid=0, rsp_rdata=0, wr_done=0.
- Reset mid-transaction: the transaction is abandoned, the bus is released immediately, and no response is emitted.
- Enqueue: a request is accepted on a rising edge when req_valid && req_ready. req_ready = !full.
- Same-edge enqueue and dequeue on a full queue: allowed only if the dequeue occurs. req_ready is computed from registered occupancy, so the core sees req_ready=0 when full.
- Queue wrap-around: pointers are log2(QDEPTH) bits and wrap modulo QDEPTH. Occupancy is a count of width log2(QDEPTH)+1.
- IDLE: if the queue is not empty, dequeue the head and go to ISSUE on the next edge; mem_valid=0.
- ISSUE, exactly 1 cycle:
  - mem_valid=1; mem_addr=head addr; mem_rw=head rw.
  - For a write, mem_data is driven with wdata; for a read, mem_data stays 'z.
  - Next state is WAIT_RD or WAIT_WR.
- WAIT_RD:
  - mem_valid=0; mem_addr and mem_rw are held; mem_data is 'z.
  - A counter runs from 1. At the RD_LAT-th edge after the ISSUE edge, mem_data is registered into rsp_rdata and rsp_valid=1 for one cycle.
  - Next state is TURN.
- WAIT_WR:
  - mem_valid=0; mem_addr, mem_rw and mem_data are held.
  - After WR_HOLD total driven cycles, mem_data is released, wr_done pulses for one cycle, and the FSM goes to TURN.
- TURN, 1 cycle bus turnaround: mem_data is 'z and mem_valid=0; next state is IDLE.
- Minimum transaction time:
  - Read: 1+RD_LAT+1 cycles (4 at defaults).
  - Write: WR_HOLD+1 cycles (3 at defaults).
  - Back-to-back requests therefore never overlap on the bus.
- mem_data is driven only in ISSUE(write) and WAIT_WR. The bus is never driven while mem_rw=1.
- Addresses pass through unmodified; the responder discards addr[1:0].
- req_valid while the queue is full: the request is not accepted, and the core must hold it stable.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- With the macro:
  - Adds output port align_err (1 bit, reset 0).
  - A request with req_addr[1:0]!=0 is still handshaken (consumed) but not enqueued.
  - align_err pulses for one cycle on the following edge.
  - No bus activity and no rsp_valid/wr_done for that request.
- Without the macro: no align_err port; all addresses are enqueued and issued unchanged.

Decomposition:
- In InstructionStruct: DWIDTH, CPUAWIDTH, AWIDTH (already present).
- Add to InstructionStruct:
  - a typedef enum logic [2:0] for the FSM states {IDLE, ISSUE, WAIT_RD, WAIT_WR, TURN};
  - a packed struct mem_req_t {rw, addr[CPUAWIDTH], wdata[DWIDTH]} for queue entries;
  - localparams MEM_RD=1'b1 and MEM_WR=1'b0.
- Sub-module req_fifo: parameterised synchronous FIFO of mem_req_t with push, pop, full, empty; async active-low reset. The FSM and bus drivers stay in mem_requester.

Test Plan:
- Single read:
  - Stimulus: push rw=1, addr=0x0000_0010; model the responder returning 0xDEADBEEF on mem_data.
  - Required: mem_valid high for exactly 1 cycle with mem_addr=0x10; mem_data is 'z from our side throughout; rsp_valid pulses 2 edges after ISSUE with rsp_rdata=0xDEADBEEF.
- Single write:
  - Stimulus: push rw=0, addr=0x24, wdata=0x12345678.
  - Required: mem_data=0x12345678 for exactly 2 cycles starting at ISSUE; then 'z; wr_done pulses once; the responder model stores at word 9.
- Queue full:
  - Stimulus: hold req_valid with 3 back-to-back writes while the bus is busy.
  - Required: req_ready=0 after 2 are queued; the 3rd is accepted only after a dequeue; the order on the bus is preserved.
- Back-to-back read-write-read:
  - Required: each transaction is separated by a TURN cycle with mem_valid=0; mem_data is never driven while mem_rw=1; response data is in order.
- Reset mid-read:
  - Stimulus: assert reset=0 during WAIT_RD.
  - Required: outputs return to reset values immediately (asynchronously); no rsp_valid; req_ready=1 after release.
- MEM_ALIGN_CHECK_EN build:
  - Stimulus: push addr=0x13.
  - Required: align_err pulses once; mem_valid stays 0; the next aligned request proceeds normally.
